// File: rtl/mem_access_stage.sv
// mem_access_stage: RV64 memory-access stage between execute and write-back.
// Captures the execute result and control bits. Loads and stores go through a
// request/response data-memory port with byte strobes. Load data is aligned
// and sign/zero-extended, and upstream is stalled while an access is in flight.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid, i_alu_result,  execute-stage instruction, address or result,
//   i_rs2_data,             store data, instruction word and control bits
//   i_instruction, i_mem_*, i_reg_write
//   o_stall                 hold upstream (combinational)
//   o_dmem_*, i_dmem_*      data-memory request/response port
//   o_alu_result, o_mem_data, o_instruction, o_reg_write, o_mem_to_reg
//                           registered write-back bundle
//   o_fault                 one-cycle pulse for a misaligned or illegal access
module mem_access_stage (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic [63:0] i_alu_result,
   input  logic [63:0] i_rs2_data,
   input  logic [31:0] i_instruction,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic        i_reg_write,
   input  logic        i_mem_to_reg,
   output logic        o_stall,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [63:0] o_dmem_addr,
   output logic [63:0] o_dmem_wdata,
   output logic [7:0]  o_dmem_wstrb,
   input  logic        i_dmem_ready,
   input  logic        i_dmem_rvalid,
   input  logic [63:0] i_dmem_rdata,
   output logic [63:0] o_alu_result,
   output logic [63:0] o_mem_data,
   output logic [31:0] o_instruction,
   output logic        o_reg_write,
   output logic        o_mem_to_reg,
   output logic        o_fault
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t      state_q;

   logic [63:0] hold_alu_q;
   logic [31:0] hold_instr_q;
   logic [2:0]  hold_f3_q;
   logic        hold_we_q;
   logic        hold_rw_q;
   logic        hold_m2r_q;

   logic        req_q;
   logic        we_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [7:0]  wstrb_q;
   logic [63:0] alu_q;
   logic [63:0] mdata_q;
   logic [31:0] instr_q;
   logic        rw_q;
   logic        m2r_q;
   logic        fault_q;

   logic [2:0]  f3_in;
   logic [2:0]  off;
   logic        mem_op;
   logic        illegal;
   logic        misal;
   logic        acc_ok;
   logic [7:0]  strb_base;
   logic [7:0]  wstrb_d;
   logic [63:0] wdata_d;
   logic [63:0] ld_sh;
   logic [63:0] ldata_d;

   assign f3_in   = i_instruction[14:12];
   assign off     = i_alu_result[2:0];
   assign mem_op  = i_mem_read | i_mem_write;
   // Unsigned sizes only exist for loads; 111 is never legal.
   assign illegal = (f3_in == 3'b111) | (i_mem_write & f3_in[2]);
   assign acc_ok  = ~illegal & ~misal;

   always_comb begin
      misal     = 1'b0;
      strb_base = 8'h01;
      case (f3_in[1:0])
         2'd0: begin
            misal     = 1'b0;
            strb_base = 8'h01;
         end
         2'd1: begin
            misal     = off[0];
            strb_base = 8'h03;
         end
         2'd2: begin
            misal     = |off[1:0];
            strb_base = 8'h0F;
         end
         default: begin
            misal     = |off;
            strb_base = 8'hFF;
         end
      endcase
   end

   assign wstrb_d = strb_base << off;
   assign wdata_d = i_rs2_data << {off, 3'b000};

   // Load lane selection uses the held address, not the live input.
   assign ld_sh = i_dmem_rdata >> {hold_alu_q[2:0], 3'b000};

   always_comb begin
      ldata_d = ld_sh;
      case (hold_f3_q)
         3'b000:  ldata_d = {{56{ld_sh[7]}},  ld_sh[7:0]};
         3'b001:  ldata_d = {{48{ld_sh[15]}}, ld_sh[15:0]};
         3'b010:  ldata_d = {{32{ld_sh[31]}}, ld_sh[31:0]};
         3'b100:  ldata_d = {56'd0, ld_sh[7:0]};
         3'b101:  ldata_d = {48'd0, ld_sh[15:0]};
         3'b110:  ldata_d = {32'd0, ld_sh[31:0]};
         default: ldata_d = ld_sh;
      endcase
   end

   // Stall also covers the capture cycle so upstream holds while we latch.
   assign o_stall = (state_q != IDLE) |
                    (i_valid & mem_op & acc_ok);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         hold_alu_q   <= '0;
         hold_instr_q <= '0;
         hold_f3_q    <= '0;
         hold_we_q    <= 1'b0;
         hold_rw_q    <= 1'b0;
         hold_m2r_q   <= 1'b0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         alu_q        <= '0;
         mdata_q      <= '0;
         instr_q      <= '0;
         rw_q         <= 1'b0;
         m2r_q        <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         rw_q    <= 1'b0;
         m2r_q   <= 1'b0;
         fault_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (i_valid && !mem_op) begin
                  alu_q   <= i_alu_result;
                  instr_q <= i_instruction;
                  rw_q    <= i_reg_write;
                  m2r_q   <= i_mem_to_reg;
               end else if (i_valid) begin
                  hold_alu_q   <= i_alu_result;
                  hold_instr_q <= i_instruction;
                  hold_f3_q    <= f3_in;
                  hold_we_q    <= i_mem_write;
                  hold_rw_q    <= i_reg_write;
                  hold_m2r_q   <= i_mem_to_reg;
                  if (acc_ok) begin
                     state_q <= REQ;
                     req_q   <= 1'b1;
                     we_q    <= i_mem_write;
                     addr_q  <= {i_alu_result[63:3], 3'b000};
                     wstrb_q <= i_mem_write ? wstrb_d : 8'h00;
                     if (i_mem_write)
                        wdata_q <= wdata_d;
                  end else begin
                     alu_q   <= i_alu_result;
                     instr_q <= i_instruction;
                     fault_q <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (i_dmem_ready) begin
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  wstrb_q <= 8'h00;
                  if (hold_we_q) begin
                     state_q <= IDLE;
                     alu_q   <= hold_alu_q;
                     instr_q <= hold_instr_q;
                     rw_q    <= hold_rw_q;
                     m2r_q   <= hold_m2r_q;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (i_dmem_rvalid) begin
                  state_q <= IDLE;
                  alu_q   <= hold_alu_q;
                  mdata_q <= ldata_d;
                  instr_q <= hold_instr_q;
                  rw_q    <= hold_rw_q;
                  m2r_q   <= hold_m2r_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_dmem_req    = req_q;
   assign o_dmem_we     = we_q;
   assign o_dmem_addr   = addr_q;
   assign o_dmem_wdata  = wdata_q;
   assign o_dmem_wstrb  = wstrb_q;
   assign o_alu_result  = alu_q;
   assign o_mem_data    = mdata_q;
   assign o_instruction = instr_q;
   assign o_reg_write   = rw_q;
   assign o_mem_to_reg  = m2r_q;
   assign o_fault       = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage.
// Hand-computed vectors for ALU pass-through, stores, loads, faults, reset.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [63:0] alu;
   logic [63:0] rs2;
   logic [31:0] instr;
   logic        mrd, mwr, rwr, m2r;
   logic        stall;
   logic        req, we;
   logic [63:0] addr, wdata;
   logic [7:0]  wstrb;
   logic        ready, rvalid;
   logic [63:0] rdata;
   logic [63:0] alu_o, mdata_o;
   logic [31:0] instr_o;
   logic        rw_o, m2r_o, fault_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_valid       (valid),
      .i_alu_result  (alu),
      .i_rs2_data    (rs2),
      .i_instruction (instr),
      .i_mem_read    (mrd),
      .i_mem_write   (mwr),
      .i_reg_write   (rwr),
      .i_mem_to_reg  (m2r),
      .o_stall       (stall),
      .o_dmem_req    (req),
      .o_dmem_we     (we),
      .o_dmem_addr   (addr),
      .o_dmem_wdata  (wdata),
      .o_dmem_wstrb  (wstrb),
      .i_dmem_ready  (ready),
      .i_dmem_rvalid (rvalid),
      .i_dmem_rdata  (rdata),
      .o_alu_result  (alu_o),
      .o_mem_data    (mdata_o),
      .o_instruction (instr_o),
      .o_reg_write   (rw_o),
      .o_mem_to_reg  (m2r_o),
      .o_fault       (fault_o)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      valid = 1'b0;
      mrd   = 1'b0;
      mwr   = 1'b0;
      rwr   = 1'b0;
      m2r   = 1'b0;
   endtask

   task automatic do_store(input string tag,
                           input logic [63:0] a,
                           input logic [2:0]  f3,
                           input logic [63:0] d,
                           input logic [63:0] e_addr,
                           input logic [7:0]  e_strb,
                           input logic [63:0] e_wdata,
                           input int          delay);
      valid = 1'b1;
      mwr   = 1'b1;
      alu   = a;
      rs2   = d;
      instr = {17'd0, f3, 5'd0, 7'h23};
      #1;
      chk({tag, "_stall_cap"}, stall, 1);
      tick();
      idle_in();
      rs2 = 64'h5555_5555_5555_5555;
      for (int i = 0; i <= delay; i++) begin
         chk({tag, "_req"}, req, 1);
         chk({tag, "_we"}, we, 1);
         chk({tag, "_addr"}, addr, e_addr);
         chk({tag, "_strb"}, wstrb, e_strb);
         chk({tag, "_wdata"}, wdata, e_wdata);
         chk({tag, "_stall"}, stall, 1);
         if (i == delay) ready = 1'b1;
         tick();
      end
      ready = 1'b0;
      chk({tag, "_req_done"}, req, 0);
      chk({tag, "_rw_done"}, rw_o, 0);
      chk({tag, "_alu_done"}, alu_o, a);
      chk({tag, "_stall_done"}, stall, 0);
   endtask

   task automatic do_load(input string tag,
                          input logic [63:0] a,
                          input logic [2:0]  f3,
                          input logic [63:0] rd,
                          input logic [63:0] e_addr,
                          input logic [63:0] e_data);
      valid = 1'b1;
      mrd   = 1'b1;
      rwr   = 1'b1;
      m2r   = 1'b1;
      alu   = a;
      instr = {17'd0, f3, 5'd0, 7'h03};
      #1;
      chk({tag, "_stall_cap"}, stall, 1);
      tick();
      idle_in();
      chk({tag, "_req"}, req, 1);
      chk({tag, "_we"}, we, 0);
      chk({tag, "_addr"}, addr, e_addr);
      chk({tag, "_strb"}, wstrb, 0);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk({tag, "_wait_req"}, req, 0);
      chk({tag, "_wait_stall"}, stall, 1);
      chk({tag, "_wait_rw"}, rw_o, 0);
      rvalid = 1'b1;
      rdata  = rd;
      tick();
      rvalid = 1'b0;
      chk({tag, "_data"}, mdata_o, e_data);
      chk({tag, "_rw"}, rw_o, 1);
      chk({tag, "_m2r"}, m2r_o, 1);
      chk({tag, "_alu"}, alu_o, a);
      chk({tag, "_stall_done"}, stall, 0);
      tick();
      chk({tag, "_rw_pulse"}, rw_o, 0);
   endtask

   task automatic do_fault(input string tag,
                           input logic [63:0] a,
                           input logic [2:0]  f3,
                           input logic        st);
      valid = 1'b1;
      mrd   = ~st;
      mwr   = st;
      rwr   = ~st;
      m2r   = ~st;
      alu   = a;
      instr = {17'd0, f3, 5'd0, st ? 7'h23 : 7'h03};
      #1;
      chk({tag, "_stall"}, stall, 0);
      tick();
      idle_in();
      chk({tag, "_fault"}, fault_o, 1);
      chk({tag, "_req"}, req, 0);
      chk({tag, "_rw"}, rw_o, 0);
      chk({tag, "_m2r"}, m2r_o, 0);
      tick();
      chk({tag, "_fault_pulse"}, fault_o, 0);
      chk({tag, "_req_after"}, req, 0);
   endtask

   initial begin
      rst    = 1'b1;
      idle_in();
      alu    = '0;
      rs2    = '0;
      instr  = '0;
      ready  = 1'b0;
      rvalid = 1'b0;
      rdata  = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_req", req, 0);
      chk("rst_we", we, 0);
      chk("rst_strb", wstrb, 0);
      chk("rst_rw", rw_o, 0);
      chk("rst_fault", fault_o, 0);
      chk("rst_alu", alu_o, 0);
      chk("rst_mdata", mdata_o, 0);
      chk("rst_addr", addr, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_stall", stall, 0);

      valid = 1'b1;
      rwr   = 1'b1;
      alu   = 64'h1234;
      instr = 32'h0000_0033;
      #1;
      chk("add_stall_cap", stall, 0);
      tick();
      idle_in();
      chk("add_alu", alu_o, 64'h1234);
      chk("add_rw", rw_o, 1);
      chk("add_instr", instr_o, 32'h0000_0033);
      chk("add_stall", stall, 0);
      tick();
      chk("add_rw_pulse", rw_o, 0);
      chk("add_alu_hold", alu_o, 64'h1234);

      do_store("sd", 64'h100, 3'b011, 64'hDEAD_BEEF_CAFE_F00D,
               64'h100, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 3);
      do_store("sh", 64'h106, 3'b001, 64'hABCD,
               64'h100, 8'hC0, 64'hABCD_0000_0000_0000, 0);
      do_store("sb", 64'h105, 3'b000, 64'h77,
               64'h100, 8'h20, 64'h0000_7700_0000_0000, 1);

      do_load("lb", 64'h203, 3'b000, 64'h0000_0000_8000_0000,
              64'h200, 64'hFFFF_FFFF_FFFF_FF80);
      do_load("lbu", 64'h203, 3'b100, 64'h0000_0000_8000_0000,
              64'h200, 64'h80);
      do_load("lh", 64'h206, 3'b001, 64'h8001_0000_0000_0000,
              64'h200, 64'hFFFF_FFFF_FFFF_8001);
      do_load("lw", 64'h204, 3'b010, 64'h89AB_CDEF_0000_0000,
              64'h200, 64'hFFFF_FFFF_89AB_CDEF);
      do_load("lwu", 64'h204, 3'b110, 64'h89AB_CDEF_0000_0000,
              64'h200, 64'h89AB_CDEF);
      do_load("ld", 64'h208, 3'b011, 64'h0123_4567_89AB_CDEF,
              64'h208, 64'h0123_4567_89AB_CDEF);

      do_fault("lw_mis", 64'h102, 3'b010, 1'b0);
      do_fault("sd_mis", 64'h104, 3'b011, 1'b1);
      do_fault("st_f3_4", 64'h100, 3'b100, 1'b1);
      do_fault("ld_f3_7", 64'h100, 3'b111, 1'b0);

      rvalid = 1'b1;
      rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      rvalid = 1'b0;
      chk("idle_rvalid_rw", rw_o, 0);
      chk("idle_rvalid_data", mdata_o, 64'h0123_4567_89AB_CDEF);

      rst   = 1'b1;
      tick();
      rst   = 1'b0;
      valid = 1'b1;
      mrd   = 1'b1;
      rwr   = 1'b1;
      m2r   = 1'b1;
      alu   = 64'h300;
      instr = {17'd0, 3'b011, 5'd0, 7'h03};
      tick();
      idle_in();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("rstw_stall", stall, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstw_req", req, 0);
      chk("rstw_stall_idle", stall, 0);
      rvalid = 1'b1;
      rdata  = 64'h1111_2222_3333_4444;
      tick();
      rvalid = 1'b0;
      chk("rstw_rw", rw_o, 0);
      chk("rstw_m2r", m2r_o, 0);
      chk("rstw_data", mdata_o, 0);
      chk("rstw_stall_end", stall, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
